i2c_slave_regs: RTL
===================

Name: i2c_slave_regs

Overview:
- Synthesizable I2C target with an internal byte register bank; sits downstream on the bus driven by I2C_TOP (master) and replaces the behavioural slave model in the system bench.
- Oversamples SCL/SDA in the system clock domain, decodes START/STOP, matches a 7-bit address, and supports register-pointer writes, burst writes and burst reads with pointer auto-increment.
- Exposes a write-notify strobe and a local read port to on-chip logic.

Parameters:
- SLAVE_ADDR, 7'h10, 7-bit bus address this target answers to.
- AW, 4, register pointer width; bank depth is 2**AW bytes.

Ports:
- clk  input  1  system clock; must be at least 16x the SCL frequency.
- rst_n  input  1  asynchronous active-low reset.
- scl  input  1  I2C clock; no clock stretching, never driven.
- i2c_sda  inout  1  I2C data, open-drain: driven 0 or high-Z only.
- reg_rd_addr  input  AW  local combinational read address.
- reg_rd_data  output  8  reg[reg_rd_addr], combinational.
- wr_strobe  output  1  one-cycle pulse per bus data byte written.
- wr_addr  output  AW  register index of the last write.
- wr_data  output  8  data of the last write.
- busy  output  1  high from a START until STOP or address mismatch.

Behaviour:
- Reset values: SDA released (high-Z), all registers 0x00, pointer 0, wr_strobe 0, wr_addr 0, wr_data 0, busy 0, state IDLE. Reset is asynchronous, so SDA release takes effect immediately even mid-byte.
- Input path: 2-FF synchronizers on scl and sda, then a 1-cycle edge detect. Bus event to internal action latency is 3 clk.
- START: synced SDA falls while synced SCL is high. STOP: synced SDA rises while SCL is high.
  - Both are recognised in every state and take priority over bit processing.
  - START: go to ADDR, bit count 0, busy=1, pointer retained (supports repeated START).
  - STOP: go to IDLE, busy=0.
- Timing rule: data sampled on SCL rise; slave SDA changes only on SCL fall.
- States:
  - IDLE: wait for START.
  - ADDR: shift 8 bits MSB first. If byte[7:1]==SLAVE_ADDR, go to ADDR_ACK and latch rw=byte[0]. Otherwise go to IDLE, busy=0, SDA untouched.
  - ADDR_ACK: drive SDA low from the next SCL fall to the following SCL fall. Then go to PTR if rw=0, or RD_DATA if rw=1.
  - PTR: 8 bits; pointer=byte[AW-1:0], upper bits ignored. Then PTR_ACK (always ACK), then WR_DATA.
  - WR_DATA: 8 bits.
    - On the 8th SCL rise: reg[ptr]<=byte, wr_strobe=1 for one clk, wr_addr=ptr, wr_data=byte, ptr<=ptr+1.
    - Then WR_ACK (always ACK), then WR_DATA.
  - RD_DATA: load reg[ptr] on entry; drive each bit on SCL fall, MSB first. Release SDA on the SCL fall after bit 0, then go to RD_ACK.
  - RD_ACK: sample master ACK on SCL rise.
    - ACK (0): ptr<=ptr+1, go to RD_DATA.
    - NACK (1): go to IDLE, SDA stays released; busy remains 1 until STOP.
- Pointer wraps 2**AW-1 -> 0 for both reads and writes.
- Local read port never stalls the bus. A wr_strobe to the same index is visible on reg_rd_data the next clk.
- A START or STOP inside a byte aborts it: no partial write, no strobe, SDA released within 3 clk.

Optional Feature:
- Macro: I2C_GLITCH_FILT_EN.
- Defined: after the synchronizers, each of scl/sda passes a filter that changes its output only after 3 consecutive equal samples. Pulses of 2 clk or shorter are rejected. Event latency rises to 5 clk.
- Undefined: synchronized signals are used directly; latency is 3 clk.

Test Plan:
- Master writes to 0x10, bytes 01,BB,06,04, then STOP -> slave ACKs all 5 bytes; three wr_strobe pulses (1,BB),(2,06),(3,04); reg_rd_addr=2 gives 06; busy 0 after STOP.
- Address 0x11 write -> SDA never pulled low by slave, NACK seen by master, no wr_strobe, busy drops after the address byte.
- After the first test: write ptr 01, repeated START, read 3 bytes with master ACK,ACK,NACK -> bus carries BB,06,04; SDA released after the NACK; ptr ends at 4.
- ptr 0F, write AA,55 -> reg[15]=AA, reg[0]=55, wr_addr sequence 15,0.
- rst_n asserted during the 4th bit of a read byte -> SDA high-Z in the same cycle, all regs 00, busy 0; next transaction to 0x10 ACKs normally.
- 2-clk SDA low pulse while SCL high in IDLE:
  - macro defined -> no START, busy stays 0.
  - macro undefined -> START detected, busy=1.

Source files
------------

// File: rtl/i2c_slave_regs_if.sv
// Local-side port bundle of i2c_slave_regs: register read port and write-notify outputs.
// The slave modport belongs to the I2C target; the master modport belongs to on-chip logic.
interface i2c_slave_regs_if #(
  parameter int unsigned AW = 4
);
  logic [AW-1:0] reg_rd_addr;
  logic [7:0]    reg_rd_data;
  logic          wr_strobe;
  logic [AW-1:0] wr_addr;
  logic [7:0]    wr_data;
  logic          busy;

  modport slave (
    input  reg_rd_addr,
    output reg_rd_data,
    output wr_strobe,
    output wr_addr,
    output wr_data,
    output busy
  );

  modport master (
    output reg_rd_addr,
    input  reg_rd_data,
    input  wr_strobe,
    input  wr_addr,
    input  wr_data,
    input  busy
  );
endinterface

// File: rtl/i2c_slave_regs.sv
// I2C target with a 2**AW byte register bank, pointer writes, burst writes and burst reads.
// Optional macro I2C_GLITCH_FILT_EN adds a 3-sample glitch filter on scl/sda.
module i2c_slave_regs #(
  parameter logic [6:0]  SLAVE_ADDR = 7'h10,
  parameter int unsigned AW         = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               scl,
  inout  wire                i2c_sda,
  i2c_slave_regs_if.slave    loc
);

  localparam int unsigned DEPTH = 2 ** AW;

  typedef enum logic [3:0] {
    S_IDLE, S_ADDR, S_ADDR_ACK, S_PTR, S_PTR_ACK,
    S_WR_DATA, S_WR_ACK, S_RD_DATA, S_RD_ACK
  } state_e;

  // Input synchronizers (bus idles high)
  logic [1:0] scl_sync_q, scl_sync_d;
  logic [1:0] sda_sync_q, sda_sync_d;
  logic       scl_c, sda_c;
  logic       scl_lvl_q, sda_lvl_q;

  always_comb begin
    scl_sync_d = {scl_sync_q[0], scl};
    sda_sync_d = {sda_sync_q[0], i2c_sda};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_sync_q <= 2'b11;
      sda_sync_q <= 2'b11;
      scl_lvl_q  <= 1'b1;
      sda_lvl_q  <= 1'b1;
    end else begin
      scl_sync_q <= scl_sync_d;
      sda_sync_q <= sda_sync_d;
      scl_lvl_q  <= scl_c;
      sda_lvl_q  <= sda_c;
    end
  end

`ifdef I2C_GLITCH_FILT_EN
  // Level moves only once the synced value has held for three samples
  logic [1:0] scl_hist_q, scl_hist_d;
  logic [1:0] sda_hist_q, sda_hist_d;

  always_comb begin
    scl_hist_d = {scl_hist_q[0], scl_sync_q[1]};
    sda_hist_d = {sda_hist_q[0], sda_sync_q[1]};
    scl_c = ((scl_sync_q[1] == scl_hist_q[0]) && (scl_sync_q[1] == scl_hist_q[1]))
            ? scl_sync_q[1] : scl_lvl_q;
    sda_c = ((sda_sync_q[1] == sda_hist_q[0]) && (sda_sync_q[1] == sda_hist_q[1]))
            ? sda_sync_q[1] : sda_lvl_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_hist_q <= 2'b11;
      sda_hist_q <= 2'b11;
    end else begin
      scl_hist_q <= scl_hist_d;
      sda_hist_q <= sda_hist_d;
    end
  end
`else
  always_comb begin
    scl_c = scl_sync_q[1];
    sda_c = sda_sync_q[1];
  end
`endif

  logic scl_rise, scl_fall, start_ev, stop_ev;

  always_comb begin
    scl_rise = scl_c & ~scl_lvl_q;
    scl_fall = ~scl_c & scl_lvl_q;
    start_ev = scl_c & scl_lvl_q & ~sda_c & sda_lvl_q;
    stop_ev  = scl_c & scl_lvl_q & sda_c & ~sda_lvl_q;
  end

  state_e        state_q, state_d;
  logic [3:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    shift_q, shift_d;
  logic [AW-1:0] ptr_q, ptr_d;
  logic          rw_q, rw_d;
  logic          ack_phase_q, ack_phase_d;
  logic          sda_oe_q, sda_oe_d;
  logic          busy_q, busy_d;
  logic          wr_strobe_q, wr_strobe_d;
  logic [AW-1:0] wr_addr_q, wr_addr_d;
  logic [7:0]    wr_data_q, wr_data_d;
  logic [7:0]    regs_q [DEPTH];
  logic [7:0]    regs_d [DEPTH];

  logic [7:0]    rx_byte;
  logic          last_bit;
  logic          addr_match;
  logic [AW-1:0] ptr_inc;
  logic [7:0]    rd_byte, rd_next;

  always_comb begin
    rx_byte    = {shift_q[6:0], sda_c};
    last_bit   = (bit_cnt_q == 4'd7);
    addr_match = (rx_byte[7:1] == SLAVE_ADDR);
    ptr_inc    = ptr_q + AW'(1);
    rd_byte    = regs_q[ptr_q];
    rd_next    = regs_q[ptr_inc];
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic; START/STOP override bit processing in every state
  always_comb begin
    state_d = state_q;
    if (start_ev) begin
      state_d = S_ADDR;
    end else if (stop_ev) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_ADDR:     if (scl_rise && last_bit) state_d = addr_match ? S_ADDR_ACK : S_IDLE;
        S_ADDR_ACK: if (scl_fall && ack_phase_q) state_d = rw_q ? S_RD_DATA : S_PTR;
        S_PTR:      if (scl_rise && last_bit) state_d = S_PTR_ACK;
        S_PTR_ACK,
        S_WR_ACK:   if (scl_fall && ack_phase_q) state_d = S_WR_DATA;
        S_WR_DATA:  if (scl_rise && last_bit) state_d = S_WR_ACK;
        S_RD_DATA:  if (scl_fall && (bit_cnt_q == 4'd8)) state_d = S_RD_ACK;
        S_RD_ACK:   if (scl_rise) state_d = sda_c ? S_IDLE : S_RD_DATA;
        default:    state_d = state_q;
      endcase
    end
  end

  // Datapath and output next values
  always_comb begin
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    ptr_d       = ptr_q;
    rw_d        = rw_q;
    ack_phase_d = ack_phase_q;
    sda_oe_d    = sda_oe_q;
    busy_d      = busy_q;
    wr_strobe_d = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    regs_d      = regs_q;

    if (start_ev) begin
      bit_cnt_d   = 4'd0;
      busy_d      = 1'b1;
      sda_oe_d    = 1'b0;
      ack_phase_d = 1'b0;
    end else if (stop_ev) begin
      busy_d      = 1'b0;
      sda_oe_d    = 1'b0;
      ack_phase_d = 1'b0;
    end else begin
      case (state_q)
        S_ADDR, S_PTR, S_WR_DATA: begin
          if (scl_rise) begin
            shift_d   = rx_byte;
            bit_cnt_d = 4'(bit_cnt_q + 4'd1);
            if (last_bit) begin
              bit_cnt_d   = 4'd0;
              ack_phase_d = 1'b0;
              if (state_q == S_ADDR) begin
                if (addr_match) rw_d   = rx_byte[0];
                else            busy_d = 1'b0;
              end else if (state_q == S_PTR) begin
                ptr_d = rx_byte[AW-1:0];
              end else begin
                regs_d[ptr_q] = rx_byte;
                wr_strobe_d   = 1'b1;
                wr_addr_d     = ptr_q;
                wr_data_d     = rx_byte;
                ptr_d         = ptr_inc;
              end
            end
          end
        end
        S_ADDR_ACK, S_PTR_ACK, S_WR_ACK: begin
          if (scl_fall) begin
            if (!ack_phase_q) begin
              sda_oe_d    = 1'b1;
              ack_phase_d = 1'b1;
            end else begin
              ack_phase_d = 1'b0;
              sda_oe_d    = 1'b0;
              bit_cnt_d   = 4'd0;
              // The fall ending a read-address ACK also launches the first data bit
              if ((state_q == S_ADDR_ACK) && rw_q) begin
                sda_oe_d  = ~rd_byte[7];
                shift_d   = {rd_byte[6:0], 1'b0};
                bit_cnt_d = 4'd1;
              end
            end
          end
        end
        S_RD_DATA: begin
          if (scl_fall) begin
            if (bit_cnt_q == 4'd8) begin
              sda_oe_d = 1'b0;
            end else begin
              sda_oe_d  = ~shift_q[7];
              shift_d   = {shift_q[6:0], 1'b0};
              bit_cnt_d = 4'(bit_cnt_q + 4'd1);
            end
          end
        end
        S_RD_ACK: begin
          // Pointer moves past every transmitted byte, including the NACKed last one
          if (scl_rise) begin
            ptr_d = ptr_inc;
            if (!sda_c) begin
              shift_d   = rd_next;
              bit_cnt_d = 4'd0;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt_q   <= 4'd0;
      shift_q     <= 8'h00;
      ptr_q       <= '0;
      rw_q        <= 1'b0;
      ack_phase_q <= 1'b0;
      sda_oe_q    <= 1'b0;
      busy_q      <= 1'b0;
      wr_strobe_q <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= 8'h00;
      for (int i = 0; i < DEPTH; i++) regs_q[i] <= 8'h00;
    end else begin
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      ptr_q       <= ptr_d;
      rw_q        <= rw_d;
      ack_phase_q <= ack_phase_d;
      sda_oe_q    <= sda_oe_d;
      busy_q      <= busy_d;
      wr_strobe_q <= wr_strobe_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      for (int i = 0; i < DEPTH; i++) regs_q[i] <= regs_d[i];
    end
  end

  assign i2c_sda         = sda_oe_q ? 1'b0 : 1'bz;
  assign loc.reg_rd_data = regs_q[loc.reg_rd_addr];
  assign loc.wr_strobe   = wr_strobe_q;
  assign loc.wr_addr     = wr_addr_q;
  assign loc.wr_data     = wr_data_q;
  assign loc.busy        = busy_q;

endmodule
